// File: rtl/noc_ring_pkg.sv
// Shared types and helpers for the ring path allocator.
//   src_state_e : per-source request state (IDLE / WAIT / ACTIVE)
//   mod_dist    : hop count walking clockwise from one ring position to another
//   prefer_cw   : route preference; ties go clockwise
package noc_ring_pkg;

    localparam int DEF_N_NODES = 4;
    localparam int DEF_LEN_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } src_state_e;

    function automatic int unsigned mod_dist(input int unsigned from_i,
                                             input int unsigned to_i,
                                             input int unsigned n);
        return (to_i >= from_i) ? (to_i - from_i) : (to_i + n - from_i);
    endfunction

    function automatic logic prefer_cw(input int unsigned hops_cw,
                                       input int unsigned hops_ccw);
        return hops_cw <= hops_ccw;
    endfunction

endpackage

// File: rtl/ring_path_mask.sv
// Combinational link mask for one route around the ring.
//   src, dst : ring positions of the route end points
//   cw       : 1 = clockwise links src..dst-1, 0 = counter-clockwise links dst..src-1
//   mask     : bit i set when link i is on the route (empty when src == dst)
module ring_path_mask
    import noc_ring_pkg::*;
#(
    parameter  int N_NODES = DEF_N_NODES,
    localparam int ID_W    = $clog2(N_NODES)
) (
    input  logic [ID_W-1:0]    src,
    input  logic [ID_W-1:0]    dst,
    input  logic               cw,
    output logic [N_NODES-1:0] mask
);
    localparam int DIST_W = ID_W + 1;

    logic [ID_W-1:0]   anchor;
    logic [DIST_W-1:0] span;
    logic [DIST_W-1:0] offs;

    // Link i lies on the route when its offset from the route start is below
    // the route length, both measured in the route's own direction of walk.
    always_comb begin
        anchor = cw ? src : dst;
        span   = cw ? DIST_W'(mod_dist(32'(src), 32'(dst), N_NODES))
                    : DIST_W'(mod_dist(32'(dst), 32'(src), N_NODES));
        offs   = '0;
        mask   = '0;
        for (int i = 0; i < N_NODES; i++) begin
            offs    = DIST_W'(mod_dist(32'(anchor), i, N_NODES));
            mask[i] = (offs < span);
        end
    end

endmodule

// File: rtl/ring_path_allocator.sv
// Central path allocator for a ring of N_NODES routers. Each source posts a
// (dest, len) request; the allocator reserves the shortest free route plus the
// destination ejection port for the burst and frees them when it ends.
//   clock, reset            : single clock, synchronous active-high reset
//   req_valid/dest/len      : per-source request, packed per source
//   req_ready, busy         : source is IDLE / ACTIVE
//   grant, done             : one-cycle pulses at burst start / return to IDLE
//   grant_cw                : direction of the current or last grant
//   link_cw_busy/ccw_busy   : reserved directional links (bit i = link i<->i+1)
//   eject_busy              : reserved ejection ports
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | ready for a request; bad destination pulses done, no grant
// ST_WAIT   | contends for a route every cycle
// ST_ACTIVE | holds its route; counter runs max(len,1)-1 down to 0
module ring_path_allocator
    import noc_ring_pkg::*;
#(
    parameter  int N_NODES = DEF_N_NODES,
    parameter  int LEN_W   = DEF_LEN_W,
    localparam int ID_W    = $clog2(N_NODES)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_NODES-1:0]       req_valid,
    input  logic [N_NODES*ID_W-1:0]  req_dest,
    input  logic [N_NODES*LEN_W-1:0] req_len,
    output logic [N_NODES-1:0]       req_ready,
    output logic [N_NODES-1:0]       grant,
    output logic [N_NODES-1:0]       grant_cw,
    output logic [N_NODES-1:0]       busy,
    output logic [N_NODES-1:0]       done,
    output logic [N_NODES-1:0]       link_cw_busy,
    output logic [N_NODES-1:0]       link_ccw_busy,
    output logic [N_NODES-1:0]       eject_busy
);
    localparam int DIST_W = ID_W + 1;

    src_state_e         state_q [N_NODES];
    src_state_e         state_d [N_NODES];
    logic [ID_W-1:0]    dest_q  [N_NODES];
    logic [ID_W-1:0]    dest_d  [N_NODES];
    logic [LEN_W-1:0]   cnt_q   [N_NODES];
    logic [LEN_W-1:0]   cnt_d   [N_NODES];
    logic [N_NODES-1:0] cw_q, cw_d, grant_q, grant_d, done_q, done_d;
    logic [N_NODES-1:0] link_cw_q, link_cw_d, link_ccw_q, link_ccw_d;
    logic [N_NODES-1:0] eject_q, eject_d;
    logic [ID_W-1:0]    rr_q, rr_d;

    logic [N_NODES-1:0] path_cw  [N_NODES];
    logic [N_NODES-1:0] path_ccw [N_NODES];
    logic [DIST_W-1:0]  hops_cw  [N_NODES];
    logic [DIST_W-1:0]  hops_ccw [N_NODES];
    logic [N_NODES-1:0] ok_cw, ok_ccw, pref_cw, pick_cw, elig;
    logic               win_valid;
    logic [ID_W-1:0]    win_idx;
    int                 arb_c;

    // Masks follow the latched destination, so the same pair serves both the
    // eligibility check in WAIT and the release at the end of ACTIVE.
    for (genvar s = 0; s < N_NODES; s++) begin : g_src
        ring_path_mask #(.N_NODES(N_NODES)) u_mask_cw (
            .src (ID_W'(s)),
            .dst (dest_q[s]),
            .cw  (1'b1),
            .mask(path_cw[s])
        );
        ring_path_mask #(.N_NODES(N_NODES)) u_mask_ccw (
            .src (ID_W'(s)),
            .dst (dest_q[s]),
            .cw  (1'b0),
            .mask(path_ccw[s])
        );
    end

    always_comb begin
        ok_cw   = '0;
        ok_ccw  = '0;
        pref_cw = '0;
        pick_cw = '0;
        elig    = '0;
        for (int s = 0; s < N_NODES; s++) begin
            hops_cw[s]  = DIST_W'(mod_dist(s, 32'(dest_q[s]), N_NODES));
            hops_ccw[s] = DIST_W'(mod_dist(32'(dest_q[s]), s, N_NODES));
            pref_cw[s]  = prefer_cw(32'(hops_cw[s]), 32'(hops_ccw[s]));
            ok_cw[s]    = ~|(path_cw[s] & link_cw_q) & ~eject_q[dest_q[s]];
            ok_ccw[s]   = ~|(path_ccw[s] & link_ccw_q) & ~eject_q[dest_q[s]];
            // Preferred route if free, otherwise the alternate.
            pick_cw[s]  = pref_cw[s] ? ok_cw[s] : ~ok_ccw[s];
            elig[s]     = (state_q[s] == ST_WAIT) && (ok_cw[s] || ok_ccw[s]);
        end
    end

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        arb_c     = 0;
        for (int i = 0; i < N_NODES; i++) begin
            arb_c = int'(rr_q) + i;
            if (arb_c >= N_NODES) arb_c = arb_c - N_NODES;
            if (!win_valid && elig[arb_c]) begin
                win_valid = 1'b1;
                win_idx   = ID_W'(arb_c);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        cnt_d      = cnt_q;
        cw_d       = cw_q;
        grant_d    = '0;
        done_d     = '0;
        link_cw_d  = link_cw_q;
        link_ccw_d = link_ccw_q;
        eject_d    = eject_q;
        rr_d       = rr_q;
        if (win_valid) rr_d = (32'(win_idx) == N_NODES - 1) ? '0 : win_idx + 1'b1;

        // A grant only claims resources free in the registered masks and a
        // release only clears its own, so set and clear never touch one bit.
        for (int s = 0; s < N_NODES; s++) begin
            unique case (state_q[s])
                ST_IDLE: begin
                    if (req_valid[s]) begin
                        if ({1'b0, req_dest[s*ID_W +: ID_W]} >= DIST_W'(N_NODES)) begin
                            done_d[s] = 1'b1;
                        end else begin
                            state_d[s] = ST_WAIT;
                            dest_d[s]  = req_dest[s*ID_W +: ID_W];
                            cnt_d[s]   = req_len[s*LEN_W +: LEN_W];
                        end
                    end
                end
                ST_WAIT: begin
                    if (win_valid && (win_idx == ID_W'(s))) begin
                        state_d[s] = ST_ACTIVE;
                        grant_d[s] = 1'b1;
                        cw_d[s]    = pick_cw[s];
                        cnt_d[s]   = (cnt_q[s] == '0) ? '0 : cnt_q[s] - 1'b1;
                        if (pick_cw[s]) link_cw_d  = link_cw_d  | path_cw[s];
                        else            link_ccw_d = link_ccw_d | path_ccw[s];
                        eject_d[dest_q[s]] = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt_q[s] == '0) begin
                        state_d[s] = ST_IDLE;
                        done_d[s]  = 1'b1;
                        if (cw_q[s]) link_cw_d  = link_cw_d  & ~path_cw[s];
                        else         link_ccw_d = link_ccw_d & ~path_ccw[s];
                        eject_d[dest_q[s]] = 1'b0;
                    end else begin
                        cnt_d[s] = cnt_q[s] - 1'b1;
                    end
                end
                default: state_d[s] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < N_NODES; s++) begin
                state_q[s] <= ST_IDLE;
                dest_q[s]  <= '0;
                cnt_q[s]   <= '0;
            end
            cw_q       <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            link_cw_q  <= '0;
            link_ccw_q <= '0;
            eject_q    <= '0;
            rr_q       <= '0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            cnt_q      <= cnt_d;
            cw_q       <= cw_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            link_cw_q  <= link_cw_d;
            link_ccw_q <= link_ccw_d;
            eject_q    <= eject_d;
            rr_q       <= rr_d;
        end
    end

    always_comb begin
        req_ready = '0;
        busy      = '0;
        for (int s = 0; s < N_NODES; s++) begin
            req_ready[s] = (state_q[s] == ST_IDLE);
            busy[s]      = (state_q[s] == ST_ACTIVE);
        end
    end

    assign grant         = grant_q;
    assign grant_cw      = cw_q;
    assign done          = done_q;
    assign link_cw_busy  = link_cw_q;
    assign link_ccw_busy = link_ccw_q;
    assign eject_busy    = eject_q;

endmodule

// File: tb/tb_ring_path_allocator.sv
// Directed bench for ring_path_allocator: a 4-node instance carries the main
// scenarios through a grant scoreboard, a 5-node instance covers wrap-around
// and out-of-range destinations.
module tb_ring_path_allocator;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [3:0]  req_valid4;
    logic [7:0]  req_dest4;
    logic [31:0] req_len4;
    logic [3:0]  req_ready4, grant4, grant_cw4, busy4, done4, lcw4, lccw4, ej4;

    logic [4:0]  req_valid5;
    logic [14:0] req_dest5;
    logic [39:0] req_len5;
    logic [4:0]  req_ready5, grant5, grant_cw5, busy5, done5, lcw5, lccw5, ej5;

    ring_path_allocator #(.N_NODES(4), .LEN_W(8)) u4 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid4), .req_dest(req_dest4), .req_len(req_len4),
        .req_ready(req_ready4), .grant(grant4), .grant_cw(grant_cw4),
        .busy(busy4), .done(done4), .link_cw_busy(lcw4),
        .link_ccw_busy(lccw4), .eject_busy(ej4)
    );

    ring_path_allocator #(.N_NODES(5), .LEN_W(8)) u5 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid5), .req_dest(req_dest5), .req_len(req_len5),
        .req_ready(req_ready5), .grant(grant5), .grant_cw(grant_cw5),
        .busy(busy5), .done(done5), .link_cw_busy(lcw5),
        .link_ccw_busy(lccw5), .eject_busy(ej5)
    );

    typedef struct {
        int         src;
        logic       cw;
        logic [3:0] lcw;
        logic [3:0] lccw;
        logic [3:0] ej;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic post4(input int s, input int d, input int len);
        req_valid4[s]          = 1'b1;
        req_dest4[s*2 +: 2]    = 2'(d);
        req_len4[s*8 +: 8]     = 8'(len);
    endtask

    task automatic post5(input int s, input int d, input int len);
        req_valid5[s]          = 1'b1;
        req_dest5[s*3 +: 3]    = 3'(d);
        req_len5[s*8 +: 8]     = 8'(len);
    endtask

    task automatic clr();
        req_valid4 = '0;
        req_valid5 = '0;
    endtask

    task automatic expect_grant(input int s, input logic cw, input logic [3:0] lcw,
                                input logic [3:0] lccw, input logic [3:0] ej);
        exp_t e;
        e.src = s; e.cw = cw; e.lcw = lcw; e.lccw = lccw; e.ej = ej;
        exp_q.push_back(e);
    endtask

    // Called one cycle after the handshake edge; the grant must follow one cycle later.
    task automatic wait_grant(input string tag);
        int   n;
        exp_t e;
        n = 0;
        do begin
            tick();
            n++;
        end while (grant4 == 4'b0 && n < 40);
        chk({tag, "_lat"}, n, 1);
        if (grant4 != 4'b0) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_unexpected"}, grant4, 4'b0);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_grant"}, grant4, 4'b1 << e.src);
                chk({tag, "_cw"}, grant_cw4[e.src], e.cw);
                chk({tag, "_lcw"}, lcw4, e.lcw);
                chk({tag, "_lccw"}, lccw4, e.lccw);
                chk({tag, "_eject"}, ej4, e.ej);
            end
        end
    endtask

    task automatic wait_done(input string tag, input int s, input int exp_n);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done4[s] && n < 40);
        chk(tag, n, exp_n);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (req_ready4 != 4'hf && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, req_ready4, 4'hf);
        chk({tag, "_masks"}, {lcw4, lccw4, ej4}, 12'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid4 = '0; req_dest4 = '0; req_len4 = '0;
        req_valid5 = '0; req_dest5 = '0; req_len5 = '0;

        // Request held through reset must not be served.
        post4(0, 1, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_nogrant", grant4, 4'b0);
        end
        reset = 1'b0;
        clr();
        tick();
        chk("rst_ready", req_ready4, 4'hf);
        chk("rst_masks", {lcw4, lccw4, ej4}, 12'h0);
        chk("rst_outs", {grant4, grant_cw4, busy4, done4}, 16'h0);
        chk("rst_ready5", req_ready5, 5'h1f);

        // Single transfer 0->1, len 3.
        post4(0, 1, 3);
        expect_grant(0, 1'b1, 4'b0001, 4'b0000, 4'b0010);
        tick();
        clr();
        chk("single_wait", req_ready4, 4'b1110);
        wait_grant("single");
        post4(0, 2, 5);                 // ignored: source is ACTIVE
        tick();
        clr();
        chk("single_hold2", {lcw4, ej4}, 8'b0001_0010);
        tick();
        chk("single_hold3", {lcw4, ej4}, 8'b0001_0010);
        tick();
        chk("single_done", done4, 4'b0001);
        chk("single_release", {lcw4, lccw4, ej4}, 12'h0);
        chk("single_ready", req_ready4, 4'hf);
        tick();
        chk("ignored_req", {req_ready4, grant4, done4}, 12'hf00);

        // Tie 0->2: both directions 2 hops, clockwise wins.
        post4(0, 2, 2);
        expect_grant(0, 1'b1, 4'b0011, 4'b0000, 4'b0100);
        tick();
        clr();
        wait_grant("tie");
        wait_done("tie_len2", 0, 2);

        // len 0 runs one cycle; 1->0 is shorter counter-clockwise.
        post4(1, 0, 0);
        expect_grant(1, 1'b0, 4'b0000, 4'b0001, 4'b0001);
        tick();
        clr();
        wait_grant("len0");
        wait_done("len0_one_cycle", 1, 1);
        wait_idle("after_len0");

        // Ejection port contention, then release-before-reuse.
        post4(0, 1, 10);
        expect_grant(0, 1'b1, 4'b0001, 4'b0000, 4'b0010);
        tick();
        clr();
        wait_grant("alt_src0");
        post4(3, 1, 2);
        expect_grant(3, 1'b1, 4'b1001, 4'b0000, 4'b0010);
        tick();
        clr();
        chk("alt_src3_waits", req_ready4, 4'b0110);
        wait_done("alt_done_len10", 0, 9);
        chk("alt_no_same_edge", grant4, 4'b0);
        chk("alt_eject_free", ej4, 4'b0);
        wait_grant("alt_src3");
        wait_done("alt_src3_len2", 3, 2);

        // Link 2->3 held by 1->3, so 2->0 must go counter-clockwise.
        post4(1, 3, 8);
        expect_grant(1, 1'b1, 4'b0110, 4'b0000, 4'b1000);
        tick();
        clr();
        wait_grant("ccw_src1");
        post4(2, 0, 3);
        expect_grant(2, 1'b0, 4'b0110, 4'b0011, 4'b1001);
        tick();
        clr();
        wait_grant("ccw_src2");
        wait_idle("after_ccw");

        // Reset mid-burst drops everything without a done pulse.
        post4(0, 1, 10);
        expect_grant(0, 1'b1, 4'b0001, 4'b0000, 4'b0010);
        tick();
        clr();
        wait_grant("midrst");
        reset = 1'b1;
        tick();
        chk("midrst_masks", {lcw4, lccw4, ej4}, 12'h0);
        chk("midrst_outs", {busy4, done4, grant4}, 12'h0);
        chk("midrst_ready", req_ready4, 4'hf);
        reset = 1'b0;
        tick();
        chk("midrst_nodone", done4, 4'b0);

        // Round robin from rr=0: sources 1,2,3 self-transfers in order.
        post4(1, 1, 5);
        post4(2, 2, 5);
        post4(3, 3, 5);
        expect_grant(1, 1'b1, 4'b0000, 4'b0000, 4'b0010);
        expect_grant(2, 1'b1, 4'b0000, 4'b0000, 4'b0110);
        expect_grant(3, 1'b1, 4'b0000, 4'b0000, 4'b1110);
        tick();
        clr();
        wait_grant("rr_1");
        wait_grant("rr_2");
        wait_grant("rr_3");
        wait_idle("after_rr");
        // rr back at 0: source 0 beats source 1.
        post4(0, 0, 1);
        post4(1, 1, 1);
        expect_grant(0, 1'b1, 4'b0000, 4'b0000, 4'b0001);
        expect_grant(1, 1'b1, 4'b0000, 4'b0000, 4'b0010);
        tick();
        clr();
        wait_grant("rr_wrap_0");
        wait_grant("rr_wrap_1");
        wait_idle("after_wrap");

        // Back-to-back request accepted in the done cycle.
        post4(2, 2, 1);
        expect_grant(2, 1'b1, 4'b0000, 4'b0000, 4'b0100);
        tick();
        clr();
        wait_grant("b2b_first");
        tick();
        chk("b2b_done", done4, 4'b0100);
        chk("b2b_ready", req_ready4[2], 1'b1);
        post4(2, 3, 1);
        expect_grant(2, 1'b1, 4'b0100, 4'b0000, 4'b1000);
        tick();
        clr();
        wait_grant("b2b_second");
        wait_idle("after_b2b");

        // N=5: out-of-range destination, then a wrapping clockwise hop.
        post5(1, 7, 3);
        tick();
        clr();
        chk("n5_bad_done", done5, 5'b00010);
        chk("n5_bad_nogrant", grant5, 5'b0);
        chk("n5_bad_ready", req_ready5, 5'h1f);
        tick();
        chk("n5_bad_quiet", {done5, busy5}, 10'h0);
        post5(4, 0, 1);
        tick();
        clr();
        tick();
        chk("n5_wrap_grant", grant5, 5'b10000);
        chk("n5_wrap_cw", grant_cw5[4], 1'b1);
        chk("n5_wrap_lcw", lcw5, 5'b10000);
        chk("n5_wrap_eject", ej5, 5'b00001);
        chk("n5_wrap_lccw", lccw5, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
